// File: rtl/div_gen.sv
// Fully pipelined signed divider: one restoring-division step per stage, result {quotient, remainder}.
// Fixed latency of DATA_W+2 cycles, one result per cycle, no handshake on the input side.
module div_gen #(
   parameter int DATA_W = 32
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
   input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
   output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
   output logic                  m_axis_dout_tvalid
);

   localparam int LATENCY = DATA_W + 2;
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY);

   // Index s holds the state after stage s; stage 0 is the operand register.
   logic [DATA_W-1:0] rem_q [0:DATA_W];
   logic [DATA_W-1:0] rem_d [0:DATA_W];
   logic [DATA_W-1:0] dq_q  [0:DATA_W];
   logic [DATA_W-1:0] dq_d  [0:DATA_W];
   logic [DATA_W:0]   dvs_q [0:DATA_W-1];
   logic [DATA_W:0]   dvs_d [0:DATA_W-1];
   logic [DATA_W:0]   qneg_q, qneg_d;
   logic [DATA_W:0]   rneg_q, rneg_d;
   logic [DATA_W:0]   dz_q, dz_d;
   logic [2*DATA_W-1:0] out_q, out_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W:0]   a_ext, b_ext;
   logic [DATA_W:0]   trial [1:DATA_W];
   logic              ge    [1:DATA_W];
   logic [DATA_W-1:0] quo, rmd;

   always_comb begin
      // Sign-extend by one bit so the magnitude of the most negative value fits.
      a_ext = {s_axis_dividend_tdata[DATA_W-1], s_axis_dividend_tdata};
      b_ext = {s_axis_divisor_tdata[DATA_W-1], s_axis_divisor_tdata};
      rem_d[0]  = '0;
      dq_d[0]   = DATA_W'(a_ext[DATA_W] ? -a_ext : a_ext);
      dvs_d[0]  = b_ext[DATA_W] ? -b_ext : b_ext;
      qneg_d[0] = s_axis_dividend_tdata[DATA_W-1] ^ s_axis_divisor_tdata[DATA_W-1];
      rneg_d[0] = s_axis_dividend_tdata[DATA_W-1];
      dz_d[0]   = (s_axis_divisor_tdata == '0);

      // dq carries unconsumed dividend bits at the top and shifts quotient bits in at the bottom.
      for (int s = 1; s <= DATA_W; s++) begin
         trial[s]  = {rem_q[s-1], dq_q[s-1][DATA_W-1]};
         ge[s]     = (trial[s] >= dvs_q[s-1]);
         rem_d[s]  = ge[s] ? DATA_W'(trial[s] - dvs_q[s-1]) : DATA_W'(trial[s]);
         dq_d[s]   = {dq_q[s-1][DATA_W-2:0], ge[s]};
         qneg_d[s] = qneg_q[s-1];
         rneg_d[s] = rneg_q[s-1];
         dz_d[s]   = dz_q[s-1];
         if (s < DATA_W) dvs_d[s] = dvs_q[s-1];
      end

      // Divide by zero naturally leaves remainder = |dividend|, so only the quotient is overridden.
      quo   = dq_q[DATA_W];
      rmd   = rem_q[DATA_W];
      out_d = {dz_q[DATA_W] ? {DATA_W{1'b1}} : (qneg_q[DATA_W] ? -quo : quo),
               rneg_q[DATA_W] ? -rmd : rmd};

      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s <= DATA_W; s++) begin
            rem_q[s] <= '0;
            dq_q[s]  <= '0;
         end
         for (int s = 0; s < DATA_W; s++) dvs_q[s] <= '0;
         qneg_q <= '0;
         rneg_q <= '0;
         dz_q   <= '0;
         out_q  <= '0;
         cnt_q  <= '0;
      end else begin
         for (int s = 0; s <= DATA_W; s++) begin
            rem_q[s] <= rem_d[s];
            dq_q[s]  <= dq_d[s];
         end
         for (int s = 0; s < DATA_W; s++) dvs_q[s] <= dvs_d[s];
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         dz_q   <= dz_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
      end
   end

   assign m_axis_dout_tdata  = out_q;
   assign m_axis_dout_tvalid = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_div_gen.sv
// Randomized bench for div_gen: C-semantics reference model, history ring keyed by sample edge,
// per-cycle compare on the falling edge, plus literal spot checks for the corner cases.
module tb_div_gen;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic          aclk = 1'b0;
   logic          rst  = 1'b1;
   logic [W-1:0]  dvd  = '0;
   logic [W-1:0]  dvs  = '0;
   logic [2*W-1:0] dout;
   logic          vld;

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;
   logic [2*W-1:0] hist [0:63];

   div_gen #(.DATA_W(W)) dut (
      .aclk                  (aclk),
      .rst                   (rst),
      .s_axis_dividend_tdata (dvd),
      .s_axis_divisor_tdata  (dvs),
      .m_axis_dout_tdata     (dout),
      .m_axis_dout_tvalid    (vld)
   );

   always #5 aclk = ~aclk;

   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      longint la, lb, q, r;
      if (b == '0) return {32'hFFFFFFFF, a};
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      return {q[31:0], r[31:0]};
   endfunction

   task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'h1;
         4: return W'($urandom_range(0, 15));
         5: return -W'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   // Record the expected result for every operand pair the DUT samples.
   always @(posedge aclk) begin
      if (rst) ecnt <= 0;
      else begin
         ecnt <= ecnt + 1;
         hist[(ecnt + 1) % 64] <= ref_div(dvd, dvs);
      end
   end

   always @(negedge aclk) begin
      if (rst) begin
         chk("rst_data", dout, '0);
         chk("rst_valid", {63'b0, vld}, '0);
      end else begin
         chk("valid", {63'b0, vld}, {63'b0, (ecnt >= LAT)});
         if (ecnt >= LAT) chk("data", dout, hist[(ecnt - LAT + 1) % 64]);
      end
   end

   task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp);
      @(posedge aclk);
      #1;
      dvd = a;
      dvs = b;
      repeat (LAT) @(posedge aclk);
      @(negedge aclk);
      chk(nm, dout, exp);
   endtask

   initial begin
      // Pin the reference model itself.
      chk("model_pos",  ref_div(32'd142, 32'd12),        64'h0000000B_0000000A);
      chk("model_neg",  ref_div(32'h80000012, 32'h12),   64'hF8E38E3A_FFFFFFFE);
      chk("model_ovf",  ref_div(32'h80000000, '1),       64'h80000000_00000000);
      chk("model_dz",   ref_div(32'd5, 32'd0),           64'hFFFFFFFF_00000005);

      #3;
      chk("reset_data", dout, '0);
      chk("reset_valid", {63'b0, vld}, '0);
      #4 rst = 1'b0;

      repeat (LAT - 1) @(posedge aclk);
      @(negedge aclk);
      chk("valid_before_fill", {63'b0, vld}, '0);
      @(posedge aclk);
      @(negedge aclk);
      chk("valid_at_fill", {63'b0, vld}, 64'd1);
      chk("zero_by_zero", dout, 64'hFFFFFFFF_00000000);

      directed("pos_142_12",  32'd142,      32'd12,       64'h0000000B_0000000A);
      directed("neg_dividend", 32'h80000012, 32'h00000012, 64'hF8E38E3A_FFFFFFFE);
      directed("m7_div_2",    -32'sd7,      32'd2,        64'hFFFFFFFD_FFFFFFFF);
      directed("7_div_m2",    32'd7,        -32'sd2,      64'hFFFFFFFD_00000001);
      directed("overflow",    32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
      directed("div_by_zero", 32'd5,        32'd0,        64'hFFFFFFFF_00000005);

      for (int i = 0; i < 1000; i++) begin
         @(posedge aclk);
         #1;
         dvd = pick();
         dvs = pick();
         if (i == 500) begin
            rst = 1'b1;
            #1;
            chk("midrst_data", dout, '0);
            chk("midrst_valid", {63'b0, vld}, '0);
         end
         if (i == 502) begin
            @(negedge aclk);
            #1 rst = 1'b0;
         end
      end

      repeat (LAT + 2) @(posedge aclk);
      @(negedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
